// File: rtl/seven_segment_scanner_if.sv
// Host-side load bus and board-side display pins of the seven-segment scanner.
// The master drives value/decimal points; the slave (scanner) drives the pins.
interface seven_segment_scanner_if #(
   parameter int DIGITS = 4
);
   logic                  i_load;
   logic [4*DIGITS-1:0]   i_data;
   logic [DIGITS-1:0]     i_dp;
   logic                  i_blank_lz;
   logic [6:0]            o_seg;
   logic                  o_dp;
   logic [DIGITS-1:0]     o_digit;
   logic                  o_frame;
   logic                  o_pending;

   modport master (
      output i_load, i_data, i_dp, i_blank_lz,
      input  o_seg, o_dp, o_digit, o_frame, o_pending
   );

   modport slave (
      input  i_load, i_data, i_dp, i_blank_lz,
      output o_seg, o_dp, o_digit, o_frame, o_pending
   );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit hex seven-segment driver with frame-synchronous loading,
// optional leading-zero blanking and a one-cycle ghost guard per digit slot.
module seven_segment_scanner #(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 1024,
   parameter int ACTIVE_LOW_SEG = 0,
   parameter int ACTIVE_LOW_DIG = 0
) (
   input  logic                     clk,
   input  logic                     rst_x,
   seven_segment_scanner_if.slave   bus
);
   localparam int                PW      = $clog2(PRESCALE);
   localparam int                IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PS_MAX  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
   localparam logic              DP_OFF  = (ACTIVE_LOW_SEG != 0);
   localparam logic [DIGITS-1:0] DIG_OFF = (ACTIVE_LOW_DIG != 0) ? '1 : '0;

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_sh_data, r_act_data;
   logic [DIGITS-1:0]     r_sh_dp, r_act_dp;
   logic                  r_pending;
   logic                  r_run;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [DIGITS-1:0]     r_digit;
   logic                  r_frame;

   logic                  w_slot_end, w_boundary;
   logic [3:0]            w_nib;
   logic [DIGITS-1:0]     w_lz;
   logic [6:0]            w_seg;
   logic [DIGITS-1:0]     w_dig;

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   assign w_slot_end = (r_presc == PS_MAX);
   assign w_boundary = w_slot_end && (r_idx == IDX_MAX);
   assign w_nib      = r_act_data[4*r_idx +: 4];

   // w_lz[n] is set when nibble n and every nibble above it are zero
   always_comb begin
      logic z;
      z    = 1'b1;
      w_lz = '0;
      for (int n = DIGITS - 1; n >= 0; n--) begin
         z       = z && (r_act_data[4*n +: 4] == 4'h0);
         w_lz[n] = z;
      end
   end

   always_comb begin
      w_seg = hex2seg(w_nib);
      if (bus.i_blank_lz && (r_idx != '0) && w_lz[r_idx])
         w_seg = 7'h00;
      w_dig = (r_presc == '0) ? '0 : (DIGITS'(1) << r_idx);
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
         if (w_slot_end)
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
   end

   // A load on the boundary cycle bypasses the shadow so it lands in the new frame
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_sh_data  <= '0;
         r_sh_dp    <= '0;
         r_act_data <= '0;
         r_act_dp   <= '0;
         r_pending  <= 1'b0;
      end else begin
         if (bus.i_load) begin
            r_sh_data <= bus.i_data;
            r_sh_dp   <= bus.i_dp;
         end
         if (w_boundary && (r_pending || bus.i_load)) begin
            r_act_data <= bus.i_load ? bus.i_data : r_sh_data;
            r_act_dp   <= bus.i_load ? bus.i_dp   : r_sh_dp;
            r_pending  <= 1'b0;
         end else if (bus.i_load) begin
            r_pending  <= 1'b1;
         end
      end
   end

   // r_run suppresses the frame pulse for the slot that starts right after reset
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_seg   <= SEG_OFF;
         r_dp    <= DP_OFF;
         r_digit <= DIG_OFF;
         r_frame <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_seg   <= w_seg ^ SEG_OFF;
         r_dp    <= r_act_dp[r_idx] ^ DP_OFF;
         r_digit <= w_dig ^ DIG_OFF;
         r_frame <= r_run && (r_presc == '0) && (r_idx == '0);
         r_run   <= 1'b1;
      end
   end

   assign bus.o_seg     = r_seg;
   assign bus.o_dp      = r_dp;
   assign bus.o_digit   = r_digit;
   assign bus.o_frame   = r_frame;
   assign bus.o_pending = r_pending;
endmodule
